// File: rtl/video_switch_sequencer_pkg.sv
// Shared definitions for the video switch sequencer: FSM states, cfg bit
// positions, default delays and delay-load clamping.
package video_switch_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BLANK,
    SWITCH,
    SETTLE,
    ENABLE
  } state_t;

  localparam int unsigned CFG_HD       = 0;
  localparam int unsigned CFG_RGB      = 1;
  localparam int unsigned CFG_EXT_SYNC = 2;
  localparam int unsigned CFG_VIDEO_EN = 3;

  localparam int unsigned DEFAULT_OFF_DELAY    = 200;
  localparam int unsigned DEFAULT_SETTLE_DELAY = 2000;

  localparam int unsigned CNT_W = 16;

  // A zero delay still occupies its state for one cycle.
  function automatic logic [CNT_W-1:0] delay_load(input int unsigned d);
    logic [CNT_W-1:0] v;
    v = d[CNT_W-1:0];
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/video_switch_sequencer_delay_counter.sv
// Loadable down-counter; expired is high during the final counted cycle.
module delay_counter
  import video_switch_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             en,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = (count <= CNT_W'(1));

endmodule

// File: rtl/video_switch_sequencer.sv
// Sequences video standard / sync select changes: blank the output, switch
// the selects, let the analog path settle, then re-enable video.
module video_switch_sequencer
  import video_switch_sequencer_pkg::*;
#(
  parameter int unsigned OFF_DELAY    = DEFAULT_OFF_DELAY,
  parameter int unsigned SETTLE_DELAY = DEFAULT_SETTLE_DELAY
) (
  input  logic       clk_20mhz,
  input  logic       reset,
  input  logic       cfg_wr,
  input  logic [7:0] cfg_data,
  output logic       hd_sd_x,
  output logic       rgb_comp_x,
  output logic       int_ext_x,
  output logic       video_oe_x,
  output logic       busy,
  output logic       done_irq,
  output logic [7:0] status
);

  localparam logic [CNT_W-1:0] OFF_LOAD    = delay_load(OFF_DELAY);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = delay_load(SETTLE_DELAY);

  state_t           state, next_state;
  logic [3:0]       target, pending, applied, req;
  logic             pending_valid, req_valid, to_blank;
  logic             cnt_load, cnt_en, cnt_expired;
  logic [CNT_W-1:0] cnt_value;
  logic             unused_cfg;

  assign unused_cfg = ^cfg_data[7:4];

  // A write landing in the ENABLE cycle is served alongside any pending one,
  // newest data winning.
  assign req_valid = cfg_wr | pending_valid;
  assign req       = cfg_wr ? cfg_data[3:0] : pending;

  delay_counter u_delay (
    .clk        (clk_20mhz),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_value),
    .en         (cnt_en),
    .expired    (cnt_expired)
  );

  always_ff @(posedge clk_20mhz) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    cnt_value  = OFF_LOAD;
    to_blank   = 1'b0;
    unique case (state)
      IDLE: begin
        if (cfg_wr) begin
          to_blank   = cfg_data[CFG_EXT_SYNC:CFG_HD] != target[CFG_EXT_SYNC:CFG_HD];
          next_state = to_blank ? BLANK : ENABLE;
        end
      end
      BLANK: begin
        cnt_en = 1'b1;
        if (cnt_expired) next_state = SWITCH;
      end
      SWITCH: begin
        cnt_load   = 1'b1;
        cnt_value  = SETTLE_LOAD;
        next_state = SETTLE;
      end
      SETTLE: begin
        cnt_en = 1'b1;
        if (cnt_expired) next_state = ENABLE;
      end
      ENABLE: begin
        if (req_valid) begin
          to_blank   = req[CFG_EXT_SYNC:CFG_HD] != target[CFG_EXT_SYNC:CFG_HD];
          next_state = to_blank ? BLANK : ENABLE;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (to_blank) cnt_load = 1'b1;
  end

  always_ff @(posedge clk_20mhz) begin
    if (reset) begin
      target        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      applied       <= '0;
      hd_sd_x       <= 1'b0;
      rgb_comp_x    <= 1'b0;
      int_ext_x     <= 1'b1;
      video_oe_x    <= 1'b1;
      done_irq      <= 1'b0;
    end else begin
      done_irq <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cfg_wr) begin
            target <= cfg_data[3:0];
            if (to_blank) video_oe_x <= 1'b1;
          end
        end
        BLANK, SETTLE: begin
          video_oe_x <= 1'b1;
          if (cfg_wr) begin
            pending       <= cfg_data[3:0];
            pending_valid <= 1'b1;
          end
        end
        SWITCH: begin
          hd_sd_x    <= target[CFG_HD];
          rgb_comp_x <= target[CFG_RGB];
          int_ext_x  <= ~target[CFG_EXT_SYNC];
          if (cfg_wr) begin
            pending       <= cfg_data[3:0];
            pending_valid <= 1'b1;
          end
        end
        ENABLE: begin
          done_irq   <= 1'b1;
          applied    <= target;
          // Chaining into BLANK keeps video off rather than flashing it on.
          video_oe_x <= to_blank ? 1'b1 : ~target[CFG_VIDEO_EN];
          if (req_valid) begin
            target        <= req;
            pending_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign status = {busy, pending_valid, 2'b00, applied};

endmodule

// File: tb/tb_video_switch_sequencer.sv
// Scoreboard bench for video_switch_sequencer with short delays.
module tb_video_switch_sequencer;

  localparam int OFF = 4;
  localparam int SET = 8;
  localparam int BLANK_LAT = OFF + SET + 3;   // cycles from cfg_wr to done_irq
  localparam int CHAIN_LAT = OFF + SET + 2;   // cycles from one done_irq to the next

  logic       clk_20mhz = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_wr = 1'b0;
  logic [7:0] cfg_data = '0;
  logic       hd_sd_x, rgb_comp_x, int_ext_x, video_oe_x, busy, done_irq;
  logic [7:0] status;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] status;
    logic [2:0] sel;
    logic       oe;
    int         lat;
  } exp_t;

  exp_t sb[$];

  video_switch_sequencer #(.OFF_DELAY(OFF), .SETTLE_DELAY(SET)) dut (
    .clk_20mhz  (clk_20mhz),
    .reset      (reset),
    .cfg_wr     (cfg_wr),
    .cfg_data   (cfg_data),
    .hd_sd_x    (hd_sd_x),
    .rgb_comp_x (rgb_comp_x),
    .int_ext_x  (int_ext_x),
    .video_oe_x (video_oe_x),
    .busy       (busy),
    .done_irq   (done_irq),
    .status     (status)
  );

  always #5 clk_20mhz = ~clk_20mhz;

  function automatic logic [2:0] sel_of(input logic [3:0] c);
    return {c[0], c[1], ~c[2]};
  endfunction

  function automatic exp_t mk(input logic [7:0] st, input logic oe, input int lat);
    exp_t e;
    e.status = st;
    e.sel    = sel_of(st[3:0]);
    e.oe     = oe;
    e.lat    = lat;
    return e;
  endfunction

  // Select outputs must only move while video is disabled.
  logic [2:0] prev_sel;
  logic       prev_valid = 1'b0;
  always @(negedge clk_20mhz) begin
    if (prev_valid && {hd_sd_x, rgb_comp_x, int_ext_x} !== prev_sel) begin
      checks++;
      if (video_oe_x !== 1'b1) begin
        errors++;
        $display("FAIL sel_while_enabled: sel %b -> %b with video_oe_x=%b",
                 prev_sel, {hd_sd_x, rgb_comp_x, int_ext_x}, video_oe_x);
      end
    end
    prev_sel   = {hd_sd_x, rgb_comp_x, int_ext_x};
    prev_valid = !reset;
  end

  task automatic step();
    @(posedge clk_20mhz);
    #1;
  endtask

  task automatic write(input logic [7:0] d);
    cfg_data = d;
    cfg_wr   = 1'b1;
    step();
    cfg_wr   = 1'b0;
  endtask

  task automatic wait_done(input int start, input int budget,
                           output int lat, output bit seen, output bit busy_low);
    seen = 0; busy_low = 0; lat = 0;
    for (int i = 1; i <= budget; i++) begin
      if (!busy) busy_low = 1;
      step();
      if (done_irq) begin
        seen = 1;
        lat  = start + i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [13:0] obs;
    reset = 1'b1; cfg_wr = 1'b1; cfg_data = 8'hFF;
    repeat (3) step();
    obs = {video_oe_x, hd_sd_x, rgb_comp_x, int_ext_x, busy, done_irq, status};
    checks++;
    if (obs !== {6'b100100, 8'h00}) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", obs, {6'b100100, 8'h00});
    end
    cfg_wr = 1'b0; reset = 1'b0;
    step();
    checks++;
    if ({busy, status} !== 9'h000) begin
      errors++;
      $display("FAIL wr_in_reset_ignored: got %h expected 000", {busy, status});
    end
  endtask

  task automatic test_blank_sequence();
    int lat; bit seen, bl; exp_t e;
    sb.push_back(mk(8'h0F, 1'b0, BLANK_LAT));
    write(8'h0F);
    checks++;
    if ({video_oe_x, busy} !== 2'b11) begin
      errors++;
      $display("FAIL blank_first_cycle: oe,busy got %b expected 11", {video_oe_x, busy});
    end
    repeat (4) step();
    checks++;
    if ({hd_sd_x, rgb_comp_x, int_ext_x} !== 3'b001) begin
      errors++;
      $display("FAIL sel_in_switch: got %b expected 001", {hd_sd_x, rgb_comp_x, int_ext_x});
    end
    step();
    checks++;
    if ({hd_sd_x, rgb_comp_x, int_ext_x, video_oe_x} !== 4'b1101) begin
      errors++;
      $display("FAIL sel_after_switch: got %b expected 1101",
               {hd_sd_x, rgb_comp_x, int_ext_x, video_oe_x});
    end
    wait_done(6, 40, lat, seen, bl);
    e = sb.pop_front();
    checks++;
    if ({seen, bl, lat[7:0], status, hd_sd_x, rgb_comp_x, int_ext_x, video_oe_x}
        !== {2'b10, e.lat[7:0], e.status, e.sel, e.oe}) begin
      errors++;
      $display("FAIL blank_done: got seen=%b busy_gap=%b lat=%0d st=%h sel=%b oe=%b expected lat=%0d st=%h sel=%b oe=%b",
               seen, bl, lat, status, {hd_sd_x, rgb_comp_x, int_ext_x}, video_oe_x,
               e.lat, e.status, e.sel, e.oe);
    end
    step();
    checks++;
    if ({done_irq, busy} !== 2'b00) begin
      errors++;
      $display("FAIL done_pulse_width: done,busy got %b expected 00", {done_irq, busy});
    end
  endtask

  task automatic test_direct();
    int lat; bit seen, bl; exp_t e;
    sb.push_back(mk(8'h07, 1'b1, 2));
    write(8'h07);
    checks++;
    if ({busy, video_oe_x, done_irq} !== 3'b100) begin
      errors++;
      $display("FAIL direct_enable_cycle: got %b expected 100", {busy, video_oe_x, done_irq});
    end
    wait_done(1, 10, lat, seen, bl);
    e = sb.pop_front();
    checks++;
    if ({seen, lat[7:0], status, hd_sd_x, rgb_comp_x, int_ext_x, video_oe_x}
        !== {1'b1, e.lat[7:0], e.status, e.sel, e.oe}) begin
      errors++;
      $display("FAIL direct_done: got seen=%b lat=%0d st=%h sel=%b oe=%b expected lat=%0d st=%h sel=%b oe=%b",
               seen, lat, status, {hd_sd_x, rgb_comp_x, int_ext_x}, video_oe_x,
               e.lat, e.status, e.sel, e.oe);
    end
  endtask

  task automatic test_pending();
    int lat; bit seen, bl; exp_t e;
    sb.push_back(mk(8'h81, 1'b1, BLANK_LAT));
    sb.push_back(mk(8'h0B, 1'b0, CHAIN_LAT));
    write(8'h01);
    step();
    write(8'h09);
    write(8'h0B);
    checks++;
    if (status !== 8'hC7) begin
      errors++;
      $display("FAIL pending_status: got %h expected c7", status);
    end
    for (int k = 0; k < 2; k++) begin
      wait_done((k == 0) ? 4 : 0, 40, lat, seen, bl);
      e = sb.pop_front();
      checks++;
      if ({seen, bl, lat[7:0], status, hd_sd_x, rgb_comp_x, int_ext_x, video_oe_x}
          !== {2'b10, e.lat[7:0], e.status, e.sel, e.oe}) begin
        errors++;
        $display("FAIL pending_done%0d: got seen=%b busy_gap=%b lat=%0d st=%h sel=%b oe=%b expected lat=%0d st=%h sel=%b oe=%b",
                 k, seen, bl, lat, status, {hd_sd_x, rgb_comp_x, int_ext_x}, video_oe_x,
                 e.lat, e.status, e.sel, e.oe);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit seen, bl; exp_t e;
    sb.push_back(mk(8'h83, 1'b1, 2));
    sb.push_back(mk(8'h0A, 1'b0, CHAIN_LAT));
    cfg_data = 8'h03; cfg_wr = 1'b1;
    step();
    cfg_data = 8'h0A;
    step();
    cfg_wr = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({done_irq, status, hd_sd_x, rgb_comp_x, int_ext_x, video_oe_x}
        !== {1'b1, e.status, e.sel, e.oe}) begin
      errors++;
      $display("FAIL b2b_first_done: got done=%b st=%h sel=%b oe=%b expected st=%h sel=%b oe=%b",
               done_irq, status, {hd_sd_x, rgb_comp_x, int_ext_x}, video_oe_x,
               e.status, e.sel, e.oe);
    end
    wait_done(0, 40, lat, seen, bl);
    e = sb.pop_front();
    checks++;
    if ({seen, bl, lat[7:0], status, hd_sd_x, rgb_comp_x, int_ext_x, video_oe_x}
        !== {2'b10, e.lat[7:0], e.status, e.sel, e.oe}) begin
      errors++;
      $display("FAIL b2b_second_done: got seen=%b busy_gap=%b lat=%0d st=%h sel=%b oe=%b expected lat=%0d st=%h sel=%b oe=%b",
               seen, bl, lat, status, {hd_sd_x, rgb_comp_x, int_ext_x}, video_oe_x,
               e.lat, e.status, e.sel, e.oe);
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit seen, bl;
    logic [13:0] obs;
    write(8'h04);
    checks++;
    if (video_oe_x !== 1'b1) begin
      errors++;
      $display("FAIL blank_disables: video_oe_x got %b expected 1", video_oe_x);
    end
    repeat (6) step();
    checks++;
    if ({hd_sd_x, rgb_comp_x, int_ext_x, busy} !== 4'b0001) begin
      errors++;
      $display("FAIL settle_sel: got %b expected 0001", {hd_sd_x, rgb_comp_x, int_ext_x, busy});
    end
    reset = 1'b1;
    step();
    obs = {video_oe_x, hd_sd_x, rgb_comp_x, int_ext_x, busy, done_irq, status};
    checks++;
    if (obs !== {6'b100100, 8'h00}) begin
      errors++;
      $display("FAIL mid_reset_values: got %h expected %h", obs, {6'b100100, 8'h00});
    end
    reset = 1'b0;
    wait_done(0, 30, lat, seen, bl);
    checks++;
    if (seen !== 1'b0 || status !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_no_done: seen=%b st=%h expected seen=0 st=00", seen, status);
    end
  endtask

  initial begin
    test_reset();
    test_blank_sequence();
    test_direct();
    test_pending();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
